hazard_control_block: RTL and testbench

HAZARD_CONTROL_BLOCK -- requirements
Module: hazard_control_block

---
 rtl/hazard_control_block.sv | 102 ++++++++++
 tb/tb_hazard_control_block.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hazard_control_block.sv
// rtl/hazard_control_block.sv - pipeline hazard FSM: load-use bubble, jump redirect/flush, halt.
module hazard_control_block #(
    parameter logic [5:0] OP_LOAD = 6'b010100,
    parameter logic [5:0] OP_JMP  = 6'b011000,
    parameter logic [5:0] OP_HLT  = 6'b010001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    output logic        stall,
    output logic        stall_pm,
    output logic        pc_mux_sel,
    output logic [15:0] jmp_loc,
    output logic        flush,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        LD_HOLD   = 3'd1,
        LD_REPLAY = 3'd2,
        JMP_TAKE  = 3'd3,
        JMP_FLUSH = 3'd4,
        HALT      = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  out_next;
    logic [5:0]  opcode;
    logic        unused_ins;

    assign opcode     = ins[31:26];
    assign unused_ins = ^ins[25:16];

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (opcode == OP_HLT)
                    state_next = HALT;
                else if (opcode == OP_JMP)
                    state_next = JMP_TAKE;
                else if (opcode == OP_LOAD)
                    state_next = LD_HOLD;
                else
                    state_next = RUN;
            end
            LD_HOLD:   state_next = LD_REPLAY;
            LD_REPLAY: state_next = RUN;
            JMP_TAKE:  state_next = JMP_FLUSH;
            JMP_FLUSH: state_next = RUN;
            HALT:      state_next = HALT;
            default:   state_next = RUN;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they
    // change only on a clock edge and never see ins combinationally.
    always_comb begin
        out_next = 5'b00000;
        case (state_next)
            LD_HOLD:   out_next = 5'b10000;
            LD_REPLAY: out_next = 5'b01000;
            JMP_TAKE:  out_next = 5'b00100;
            JMP_FLUSH: out_next = 5'b00010;
            HALT:      out_next = 5'b11001;
            default:   out_next = 5'b00000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            stall      <= 1'b0;
            stall_pm   <= 1'b0;
            pc_mux_sel <= 1'b0;
            flush      <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state <= state_next;
            {stall, stall_pm, pc_mux_sel, flush, halted} <= out_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            jmp_loc <= 16'h0000;
        else if (state == RUN && opcode != OP_HLT && opcode == OP_JMP)
            jmp_loc <= ins[15:0];
    end

    // Counts edges at which the registered stall is high; saturates.
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= 16'h0000;
        else if (stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'h0001;
    end

endmodule

// File: tb/tb_hazard_control_block.sv
// tb/tb_hazard_control_block.sv - randomized bench with sequence-queue reference model.
module tb_hazard_control_block;

    localparam logic [5:0] OP_LOAD = 6'b010100;
    localparam logic [5:0] OP_JMP  = 6'b011000;
    localparam logic [5:0] OP_HLT  = 6'b010001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins;
    logic        stall, stall_pm, pc_mux_sel, flush, halted;
    logic [15:0] jmp_loc, stall_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: current output vector {stall,stall_pm,pc_mux_sel,flush,halted}
    // plus a queue of the remaining vectors of the sequence in progress.
    logic [4:0] m_cur;
    logic [4:0] m_q[$];
    bit         m_halt;
    logic [15:0] m_jmp;
    int         m_cnt;

    hazard_control_block dut (
        .clk(clk), .reset(reset), .ins(ins),
        .stall(stall), .stall_pm(stall_pm), .pc_mux_sel(pc_mux_sel),
        .jmp_loc(jmp_loc), .flush(flush), .halted(halted),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        if (r) begin
            m_cur = 5'b0; m_q.delete(); m_halt = 0; m_jmp = 16'h0; m_cnt = 0;
        end else begin
            if (m_cur[4] && m_cnt < 65535) m_cnt++;
            if (m_halt) begin
                m_cur = 5'b11001;
            end else if (m_cur != 5'b0) begin
                m_cur = (m_q.size() > 0) ? m_q.pop_front() : 5'b0;
            end else if (op == OP_HLT) begin
                m_halt = 1; m_cur = 5'b11001;
            end else if (op == OP_JMP) begin
                m_jmp = i[15:0]; m_cur = 5'b00100; m_q.push_back(5'b00010);
            end else if (op == OP_LOAD) begin
                m_cur = 5'b10000; m_q.push_back(5'b01000);
            end
        end
    endtask

    task automatic step(input logic r, input logic [31:0] i);
        @(negedge clk);
        reset = r;
        ins = i;
        @(posedge clk);
        model(r, i);
        #1;
        check("ctl", {27'b0, stall, stall_pm, pc_mux_sel, flush, halted}, {27'b0, m_cur});
        check("jmp_loc", {16'b0, jmp_loc}, {16'b0, m_jmp});
        check("stall_count", {16'b0, stall_count}, m_cnt);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2: v[31:26] = OP_LOAD;
            3, 4, 5: v[31:26] = OP_JMP;
            6:       v[31:26] = OP_HLT;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] tgt);
        return {op, 10'b0, tgt};
    endfunction

    initial begin
        reset = 1'b1;
        ins = 32'h0;
        m_cur = 5'b0; m_halt = 0; m_jmp = 16'h0; m_cnt = 0;

        // Reset, with a halt opcode on the reset edge that must not be decoded.
        step(1, mk(OP_HLT, 16'h0));
        step(0, 32'h0);

        // Load bubble.
        step(0, mk(OP_LOAD, 16'h0));
        step(0, 32'h0);
        step(0, 32'h0);
        step(0, 32'h0);

        // Jump, then target must persist.
        step(0, mk(OP_JMP, 16'h0040));
        step(0, 32'h0);
        step(0, 32'h0);
        step(0, 32'h0);

        // Jump presented during LD_HOLD is ignored; serviced once back in RUN.
        step(0, mk(OP_LOAD, 16'h0));
        step(0, mk(OP_JMP, 16'h1234));
        step(0, mk(OP_JMP, 16'h2345));
        step(0, mk(OP_JMP, 16'h3456));
        step(0, 32'h0);
        step(0, 32'h0);

        // Back-to-back loads.
        step(0, mk(OP_LOAD, 16'h0));
        step(0, mk(OP_LOAD, 16'h0));
        step(0, mk(OP_LOAD, 16'h0));
        step(0, mk(OP_LOAD, 16'h0));
        step(0, 32'h0);

        // Reset during JMP_TAKE.
        step(0, mk(OP_JMP, 16'hBEEF));
        step(1, 32'h0);
        step(0, 32'h0);
        step(0, 32'h0);

        // Halt for 10 cycles, then reset.
        step(0, mk(OP_HLT, 16'h0));
        for (int n = 0; n < 10; n++) step(0, rand_ins());
        step(1, rand_ins());
        step(0, 32'h0);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 3000; n++)
            step(($urandom_range(0, 24) == 0), rand_ins());

        // Saturation: hold HALT long enough to pass 16'hFFFF.
        step(1, 32'h0);
        step(0, mk(OP_HLT, 16'h0));
        for (int n = 0; n < 65540; n++) step(0, rand_ins());
        check("sat_final", {16'b0, stall_count}, 32'h0000FFFF);
        step(1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
